// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader feeding the 64-point FFT: fills a frame, strobes start, then freezes it.
// Define FFT_LOADER_BITREV_EN to store sample k at index bitreverse(k).
module fft_frame_loader #(
  parameter int N_POINTS     = 64,
  parameter int DATA_W       = 16,
  parameter int START_CYCLES = 2,
  parameter int HOLD_CYCLES  = 100
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_re,
  input  logic [DATA_W-1:0]                in_im,
  input  logic                             in_last,
  output logic [N_POINTS-1:0][DATA_W-1:0]  out_re,
  output logic [N_POINTS-1:0][DATA_W-1:0]  out_im,
  output logic                             start,
  output logic                             busy,
  output logic                             frame_err
);

  localparam int IDX_W = $clog2(N_POINTS);
  localparam int CNT_W = 10;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_CNT  = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              ferr_d;
  logic                              in_ready_q, start_q, busy_q, frame_err_q;
  logic [N_POINTS-1:0][DATA_W-1:0]   re_q, im_q;
  logic                              xfer_s;
  logic [IDX_W-1:0]                  wr_idx_s;

`ifdef FFT_LOADER_BITREV_EN
  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int b = 0; b < IDX_W; b++) begin
      r[b] = k[IDX_W-1-b];
    end
    return r;
  endfunction

  assign wr_idx_s = bitrev(idx_q);
`else
  assign wr_idx_s = idx_q;
`endif

  // in_ready_q is high only in FILL outside reset, so it alone qualifies a transfer
  assign xfer_s = in_valid & in_ready_q;

  // Next-state logic: sample counting in FILL, shared down-counter for START and HOLD
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ferr_d  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (xfer_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_START;
            idx_d   = {IDX_W{1'b0}};
            cnt_d   = START_CNT;
          end else if (in_last) begin
            idx_d  = {IDX_W{1'b0}};
            ferr_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_START: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_CNT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_FILL;
        idx_d   = {IDX_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FILL;
      idx_q       <= {IDX_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_FILL);
      start_q     <= (state_d == S_START);
      busy_q      <= (state_d != S_FILL);
      frame_err_q <= ferr_d;
    end
  end

  // Frame storage: written only on accepted samples, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (xfer_s) begin
      re_q[wr_idx_s] <= in_re;
      im_q[wr_idx_s] <= in_im;
    end else begin
      re_q <= re_q;
      im_q <= im_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign out_re    = re_q;
  assign out_im    = im_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: driver feeds a frame-level model, monitor checks start/frame_err events.
module tb_fft_frame_loader;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int SC = 2;
  localparam int HC = 100;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DW-1:0]            in_re = '0;
  logic [DW-1:0]            in_im = '0;
  logic                     in_last = 1'b0;
  logic [N-1:0][DW-1:0]     out_re;
  logic [N-1:0][DW-1:0]     out_im;
  logic                     start, busy, frame_err;

  fft_frame_loader #(.N_POINTS(N), .DATA_W(DW), .START_CYCLES(SC), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_re(out_re), .out_im(out_im),
    .start(start), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit            is_frame;
    logic [15:0]   re [N];
    logic [15:0]   im [N];
  } ev_t;

  ev_t         evq[$];
  logic [15:0] mem_re [N];
  logic [15:0] mem_im [N];
  int          k_cnt = 0;
  int          last_acc_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wr_pos(input int k);
`ifdef FFT_LOADER_BITREV_EN
    int r = 0;
    for (int b = 0; b < 6; b++) begin
      if (((k >> b) & 1) == 1) r += (1 << (5 - b));
    end
    return r;
`else
    return k;
`endif
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mem_re[i] = 16'h0000;
      mem_im[i] = 16'h0000;
    end
    k_cnt = 0;
    evq.delete();
  endfunction

  function automatic void model_accept(input logic [15:0] re, input logic [15:0] im, input logic last);
    ev_t e;
    mem_re[wr_pos(k_cnt)] = re;
    mem_im[wr_pos(k_cnt)] = im;
    k_cnt++;
    last_acc_cyc = cyc;
    e.re = mem_re;
    e.im = mem_im;
    if (k_cnt == N) begin
      e.is_frame = 1'b1;
      evq.push_back(e);
      k_cnt = 0;
    end else if (last) begin
      e.is_frame = 1'b0;
      evq.push_back(e);
      k_cnt = 0;
    end
  endfunction

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last, input int gap);
    bit ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_re = re; in_im = im; in_last = last;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk); ok = (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (ok) model_accept(re, im, last);
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk); ok = (in_ready === 1'b1);
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic int arr_mismatch();
    int m = 0;
    for (int i = 0; i < N; i++) begin
      if (out_re[i] !== mem_re[i] || out_im[i] !== mem_im[i]) m++;
    end
    return m;
  endfunction

  // Monitor: pops the scoreboard on start rise / frame_err, checks strobe widths and ready-low window
  initial begin
    bit p_start = 1'b0, p_ferr = 1'b0, track = 1'b0;
    int start_run = 0, low_run = 0, ferr_run = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        p_start = 1'b0; p_ferr = 1'b0; track = 1'b0;
        start_run = 0; low_run = 0; ferr_run = 0;
      end else begin
        if (start === 1'b1 && !p_start) begin
          chk("start_latency", cyc, last_acc_cyc);
          if (evq.size() == 0 || !evq[0].is_frame) begin
            chk("start_unexpected", 1, 0);
          end else begin
            int m = 0;
            e = evq.pop_front();
            for (int i = 0; i < N; i++) begin
              if (out_re[i] !== e.re[i] || out_im[i] !== e.im[i]) m++;
            end
            chk("frame_contents", m, 0);
          end
          track = 1'b1; low_run = 0;
        end
        if (start === 1'b1) start_run++;
        if (start !== 1'b1 && p_start) begin
          chk("start_width", start_run, SC);
          start_run = 0;
        end
        if (frame_err === 1'b1) begin
          chk("ferr_with_start", start === 1'b1, 0);
          ferr_run++;
          if (!p_ferr) begin
            if (evq.size() == 0 || evq[0].is_frame) chk("ferr_unexpected", 1, 0);
            else begin e = evq.pop_front(); chk("ferr_event", 1, 1 - int'(e.is_frame)); end
          end
        end
        if (frame_err !== 1'b1 && p_ferr) begin
          chk("ferr_width", ferr_run, 1);
          ferr_run = 0;
        end
        if (track) begin
          if (in_ready === 1'b0) low_run++;
          else begin chk("ready_low_cycles", low_run, SC + HC); track = 1'b0; end
        end
        chk("busy", busy === 1'b1, track);
        p_start = (start === 1'b1);
        p_ferr  = (frame_err === 1'b1);
      end
    end
  end

  initial begin
    int first_acc;
    logic [15:0] first_re;
    model_clear();

    // Reset with in_valid asserted
    rst = 1'b0; in_valid = 1'b1; in_re = 16'hDEAD; in_im = 16'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_out_re5", out_re[5], 0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Full frame, continuous valid
    for (int k = 0; k < N; k++) send(16'(k), 16'(16'hFFFF - k), k == N - 1, 0);
    wait_ready();
    chk("out_re10", out_re[wr_pos(10)], 10);
    chk("out_im10", out_im[wr_pos(10)], 16'hFFF5);
`ifdef FFT_LOADER_BITREV_EN
    chk("bitrev_32", out_re[32], 1);
    chk("bitrev_24", out_re[24], 6);
    chk("bitrev_63", out_re[63], 63);
`endif

    // Gapped input: valid toggles every cycle
    for (int k = 0; k < N; k++) begin
      send(16'(k), 16'(16'hFFFF - k), k == N - 1, (k == 0) ? 0 : 1);
      if (k == 0) first_acc = last_acc_cyc;
    end
    chk("gapped_span", last_acc_cyc - first_acc + 1, 127);
    wait_ready();
    chk("gapped_arrays", arr_mismatch(), 0);

    // Busy window: valid held with junk during START/HOLD
    for (int k = 0; k < N; k++) send(16'($urandom), 16'($urandom), k == N - 1, 0);
    in_valid = 1'b1; in_re = 16'hDEAD; in_im = 16'hDEAD; in_last = 1'b1;
    begin
      bit ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
        @(negedge clk); ok = (in_ready === 1'b1);
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("busy_window_end", ok, 1);
    end
    @(posedge clk); #1;
    chk("busy_arrays", arr_mismatch(), 0);

    // Short frame then a random gapped frame
    for (int k = 0; k <= 20; k++) send(16'($urandom), 16'($urandom), k == 20, 0);
    first_re = 16'($urandom);
    for (int k = 0; k < N; k++) begin
      send((k == 0) ? first_re : 16'($urandom), 16'($urandom),
           (k == N - 1) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 2));
    end
    wait_ready();
    chk("after_short_re0", out_re[wr_pos(0)], first_re);

    // Reset 50 cycles into HOLD
    for (int k = 0; k < N; k++) send(16'($urandom), 16'($urandom), k == N - 1, 0);
    repeat (SC + 50) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("hold_rst_busy", busy, 0);
    chk("hold_rst_start", start, 0);
    chk("hold_rst_ready", in_ready, 0);
    model_clear();
    chk("hold_rst_arrays", arr_mismatch(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("hold_rst_release", in_ready, 1);
    @(posedge clk); #1;

    // One more random frame after the abort
    for (int k = 0; k < N; k++) send(16'($urandom), 16'($urandom), k == N - 1, $urandom_range(0, 1));
    wait_ready();
    chk("final_arrays", arr_mismatch(), 0);
    chk("scoreboard_drained", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream neighbour of the 64-point FFT.
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake and assembles them into a 64-entry parallel frame (real and imaginary arrays).
- Pulses start to the FFT once the frame is complete, then holds the frame stable for a fixed window while the FFT consumes it.
- Replaces the file-driven frame loading used in simulation with synthesizable logic.

Parameters:
- N_POINTS, 64, frame length; must be a power of two; index width is log2(N_POINTS).
- DATA_W, 16, sample width per component (two's complement, passed through unchanged).
- START_CYCLES, 2, number of cycles start is held high; legal range 1..15.
- HOLD_CYCLES, 100, cycles after start deasserts during which the frame is frozen; legal range 1..1023.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  sample present on in_re/in_im.
- in_ready  out  1  loader can accept a sample this cycle.
- in_re  in  DATA_W  real part of sample.
- in_im  in  DATA_W  imaginary part of sample.
- in_last  in  1  marks final sample of a frame; qualified by in_valid.
- out_re  out  DATA_W x N_POINTS  frame real array; drives FFT input_Re.
- out_im  out  DATA_W x N_POINTS  frame imaginary array; drives FFT input_Im.
- start  out  1  FFT start strobe.
- busy  out  1  high from frame completion until the hold window ends.
- frame_err  out  1  one-cycle pulse on a short frame.

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - state=FILL, idx=0.
  - out_re/out_im all zero.
  - start=0, busy=0, frame_err=0.
  - in_ready=0 while rst=0; in_ready=1 from the first cycle after rst returns high.
- Reset mid-operation is permitted in any state and aborts the frame; start drops the cycle after the reset edge.
- Transfer: occurs at a clk edge where in_valid=1 and in_ready=1. in_ready depends only on state, never on in_valid.
- FILL:
  - in_ready=1, busy=0.
  - Each transfer writes out_re[idx]<=in_re and out_im[idx]<=in_im, then increments idx.
- Short frame: a transfer with in_last=1 and idx<N_POINTS-1
  - The sample is written.
  - idx resets to 0 and frame_err pulses high for exactly the next cycle.
  - State remains FILL; no start is issued.
  - Array contents already written are left as-is and are overwritten by the next frame.
- Frame completion: the transfer at idx=N_POINTS-1 completes the frame whatever in_last is.
  - Next state: START; idx<=0.
- START:
  - in_ready=0, busy=1, start=1 for exactly START_CYCLES cycles, counted by a down-counter.
  - Then state goes to HOLD.
- HOLD:
  - in_ready=0, busy=1, start=0.
  - Lasts HOLD_CYCLES cycles, then returns to FILL; in_ready=1 on the first FILL cycle.
- Arrays never change outside FILL.
- Latency:
  - start rises 1 cycle after the edge accepting the last sample.
  - Minimum frame period = N_POINTS + START_CYCLES + HOLD_CYCLES cycles.
- in_valid is ignored while in_ready=0. Data is not captured, and there is no error.
- frame_err is registered and is never high in the same cycle as start.

Optional Feature:
- Macro: FFT_LOADER_BITREV_EN.
- Defined:
  - Sample k is written to index bitreverse(k) over log2(N_POINTS) bits, so the FFT receives bit-reversed input order. For N=64, k=1 -> 32 and k=6 -> 24.
  - Short-frame and completion detection still use the sequential count k.
- Undefined: natural order, index = k.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=0, start=0, busy=0, out_re[5]=0. First cycle after release: in_ready=1.
- Full frame, in_valid always high, in_re=k, in_im=16'hFFFF-k, in_last on k=63 ->
  - start high exactly 2 cycles, beginning 1 cycle after the 64th accept.
  - out_re[10]=10 and out_im[10]=16'hFFF5.
  - in_ready low for 102 cycles.
- Gapped input: in_valid toggles 1/0 each cycle -> 64 samples take 127 cycles; array contents identical to the previous test.
- Short frame: in_last on k=20 -> frame_err one-cycle pulse, no start. A following 64-sample frame then completes normally with out_re[0] equal to its first sample.
- Busy window: drive in_valid=1 with in_re=16'hDEAD throughout START/HOLD -> arrays unchanged, no frame_err.
- Reset during HOLD at cycle 50 -> busy=0 next cycle, arrays zero, in_ready=1 after release.
- With FFT_LOADER_BITREV_EN: in_re=k -> out_re[32]=1, out_re[24]=6, out_re[63]=63.
